// File: rtl/axi_read_burst_master.sv
// AXI4 read-burst master: takes a (start address, beat count) command,
// issues one INCR burst on AR, and forwards R beats through a single
// registered valid/ready output stage. Response codes and rlast placement
// are checked and folded into a sticky err flag.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for a command; cmd_ready high
// ADDR  | AR request held on the bus until arready
// DATA  | accepting R beats; the beat counter alone decides the end
// DRAIN | final beat sits in the output register; done once it leaves

module axi_read_burst_master #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 8,
    parameter int STROBE_WIDTH  = DATA_WIDTH / 8,
    parameter int SIZE_LOG2     = $clog2(STROBE_WIDTH)
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
    input  logic [7:0]               cmd_len,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    output logic [ADDRESS_WIDTH-1:0] araddr,
    output logic [7:0]               arlen,
    output logic [2:0]               arsize,
    output logic [1:0]               arburst,
    output logic                     arvalid,
    input  logic                     arready,
    input  logic [DATA_WIDTH-1:0]    rdata,
    input  logic [1:0]               rresp,
    input  logic                     rlast,
    input  logic                     rvalid,
    output logic                     rready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     done,
    output logic                     err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        DATA  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // Clears the sub-beat byte-offset bits so the burst starts aligned.
    localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK =
        ~ADDRESS_WIDTH'((1 << SIZE_LOG2) - 1);

    state_t     state;
    state_t     state_next;
    logic [8:0] beat_cnt;
    logic       cmd_fire;
    logic       beat_fire;
    logic       final_beat;

    assign arsize     = 3'(SIZE_LOG2);
    assign arburst    = 2'b01;
    assign cmd_fire   = cmd_valid && cmd_ready;
    assign beat_fire  = rvalid && rready;
    assign final_beat = (beat_cnt == 9'd1);

    // State register.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        arvalid    = 1'b0;
        rready     = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_next = ADDR;
                end
            end
            ADDR: begin
                arvalid = 1'b1;
                if (arready) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                rready = !out_valid || out_ready;
                if (rvalid && rready && final_beat) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!out_valid) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Command capture: AR fields, beat down-counter and error flag.
    always_ff @(posedge aclk) begin
        if (areset) begin
            araddr   <= '0;
            arlen    <= '0;
            beat_cnt <= '0;
            err      <= 1'b0;
        end else if (cmd_fire) begin
            araddr   <= cmd_addr & ALIGN_MASK;
            arlen    <= cmd_len;
            beat_cnt <= {1'b0, cmd_len} + 9'd1;
            err      <= 1'b0;
        end else if (beat_fire) begin
            beat_cnt <= beat_cnt - 9'd1;
            if ((rresp != 2'b00) || (rlast != final_beat)) begin
                err <= 1'b1;
            end
        end
    end

    // Output register; a new beat may load in the same cycle the old one leaves.
    always_ff @(posedge aclk) begin
        if (areset) begin
            out_data  <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else if (beat_fire) begin
            out_data  <= rdata;
            out_last  <= final_beat;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi_read_burst_master.sv
// Bench for axi_read_burst_master: a table of burst scenarios driven through
// a small slave/consumer model, plus hand-written reset sequences.

module tb_axi_read_burst_master;

    logic        aclk = 1'b0;
    logic        areset;
    logic [7:0]  cmd_addr;
    logic [7:0]  cmd_len;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [31:0] out_data;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic        done;
    logic        err;

    int checks   = 0;
    int failures = 0;

    axi_read_burst_master #(
        .DATA_WIDTH   (32),
        .ADDRESS_WIDTH(8)
    ) dut (
        .aclk     (aclk),
        .areset   (areset),
        .cmd_addr (cmd_addr),
        .cmd_len  (cmd_len),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .araddr   (araddr),
        .arlen    (arlen),
        .arsize   (arsize),
        .arburst  (arburst),
        .arvalid  (arvalid),
        .arready  (arready),
        .rdata    (rdata),
        .rresp    (rresp),
        .rlast    (rlast),
        .rvalid   (rvalid),
        .rready   (rready),
        .out_data (out_data),
        .out_last (out_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .done     (done),
        .err      (err)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [7:0]  addr;
        logic [7:0]  len;
        int          ar_delay;
        logic [31:0] base;
        int          bad_beat;
        int          rlast_beat;
        int          stall_beat;
        int          stall_len;
        logic [7:0]  exp_araddr;
        logic        exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic run_burst(input vec_t v);
        int n;
        int g;
        n = int'(v.len) + 1;
        @(negedge aclk);
        cmd_addr  = v.addr;
        cmd_len   = v.len;
        cmd_valid = 1'b1;
        g = 0;
        #1;
        while (!cmd_ready && g < 50) begin
            @(negedge aclk);
            #1;
            g++;
        end
        check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        @(negedge aclk);
        cmd_valid = 1'b0;
        cmd_addr  = 8'h00;
        cmd_len   = 8'h00;
        #1;
        check("err_cleared", 32'(err), 32'd0);
        check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
        check("arvalid_rise", 32'(arvalid), 32'd1);
        check("araddr", 32'(araddr), 32'(v.exp_araddr));
        check("arlen", 32'(arlen), 32'(v.len));
        check("arsize", 32'(arsize), 32'd2);
        check("arburst", 32'(arburst), 32'd1);
        for (int k = 0; k < v.ar_delay; k++) begin
            arready = 1'b0;
            rvalid  = 1'b1;
            rdata   = 32'hDEADBEEF;
            #1;
            check("stall_arvalid", 32'(arvalid), 32'd1);
            check("stall_araddr", 32'(araddr), 32'(v.exp_araddr));
            check("stall_arlen", 32'(arlen), 32'(v.len));
            check("stall_rready", 32'(rready), 32'd0);
            @(negedge aclk);
        end
        arready = 1'b1;
        rvalid  = 1'b0;
        #1;
        check("ar_hs_arvalid", 32'(arvalid), 32'd1);
        check("ar_hs_rready", 32'(rready), 32'd0);
        @(negedge aclk);
        arready = 1'b0;
        fork
            begin : r_driver
                int gd;
                for (int i = 0; i < n; i++) begin
                    rvalid = 1'b1;
                    rdata  = v.base + 32'(i);
                    rresp  = (i == v.bad_beat) ? 2'b10 : 2'b00;
                    rlast  = (i == v.rlast_beat);
                    gd = 0;
                    #1;
                    while (!rready && gd < 200) begin
                        @(negedge aclk);
                        #1;
                        gd++;
                    end
                    if (gd >= 200) begin
                        check("rready_timeout", 32'(rready), 32'd1);
                        break;
                    end
                    @(negedge aclk);
                end
                rvalid = 1'b0;
                rlast  = 1'b0;
                rresp  = 2'b00;
            end
            begin : consumer
                int          rec;
                int          stall_left;
                int          cyc;
                int          dones;
                logic [31:0] held;
                logic        stalled;
                rec        = 0;
                stall_left = v.stall_len;
                cyc        = 0;
                dones      = 0;
                held       = '0;
                stalled    = 1'b0;
                while (rec < n && cyc < 600) begin
                    out_ready = !(rec == v.stall_beat && stall_left > 0);
                    #1;
                    if (done) dones++;
                    if (out_valid && !out_ready) begin
                        stall_left--;
                        check("bp_rready", 32'(rready), 32'd0);
                        if (stalled) check("bp_hold", out_data, held);
                        held    = out_data;
                        stalled = 1'b1;
                    end else begin
                        stalled = 1'b0;
                    end
                    if (out_valid && out_ready) begin
                        check("beat_data", out_data, v.base + 32'(rec));
                        check("beat_last", 32'(out_last), 32'(rec == n - 1));
                        rec++;
                    end
                    @(negedge aclk);
                    cyc++;
                end
                check("beat_count", 32'(rec), 32'(n));
                out_ready = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    #1;
                    if (done) begin
                        dones++;
                        check("done_outvalid", 32'(out_valid), 32'd0);
                    end
                    @(negedge aclk);
                end
                check("done_pulses", 32'(dones), 32'd1);
                #1;
                check("cmd_ready_after", 32'(cmd_ready), 32'd1);
                check("err_final", 32'(err), 32'(v.exp_err));
            end
        join
    endtask

    initial begin
        //           addr   len  ard base          bad rlast stl sln exp_addr err
        vecs[0] = '{8'h10, 8'd0, 2, 32'hA5A5A5A5, -1, 0, -1, 0, 8'h10, 1'b0};
        vecs[1] = '{8'h23, 8'd3, 0, 32'hD0000000, -1, 3, -1, 0, 8'h20, 1'b0};
        vecs[2] = '{8'h23, 8'd3, 0, 32'hD1000000, -1, 3,  1, 3, 8'h20, 1'b0};
        vecs[3] = '{8'h40, 8'd3, 1, 32'hD2000000,  2, 3, -1, 0, 8'h40, 1'b1};
        vecs[4] = '{8'h44, 8'd3, 0, 32'hD3000000, -1, 1, -1, 0, 8'h44, 1'b1};
        vecs[5] = '{8'h81, 8'd1, 5, 32'hD4000000, -1, 1, -1, 0, 8'h80, 1'b0};
        vecs[6] = '{8'hFF, 8'd7, 1, 32'hD5000000, -1, 7,  7, 2, 8'hFC, 1'b0};

        areset    = 1'b1;
        cmd_addr  = 8'h00;
        cmd_len   = 8'h00;
        cmd_valid = 1'b0;
        arready   = 1'b0;
        rdata     = '0;
        rresp     = 2'b00;
        rlast     = 1'b0;
        rvalid    = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge aclk);
        areset = 1'b0;
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_arvalid", 32'(arvalid), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_araddr", 32'(araddr), 32'd0);
        check("rst_arlen", 32'(arlen), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_rready", 32'(rready), 32'd0);

        for (int t = 0; t < 7; t++) begin
            run_burst(vecs[t]);
        end

        // Reset after beat 1 of a four-beat burst.
        @(negedge aclk);
        cmd_addr  = 8'h30;
        cmd_len   = 8'd3;
        cmd_valid = 1'b1;
        @(negedge aclk);
        cmd_valid = 1'b0;
        arready   = 1'b1;
        @(negedge aclk);
        arready   = 1'b0;
        out_ready = 1'b1;
        rvalid    = 1'b1;
        rdata     = 32'hE0E0E0E0;
        rresp     = 2'b00;
        rlast     = 1'b0;
        @(negedge aclk);
        rdata = 32'hE1E1E1E1;
        @(negedge aclk);
        #1;
        check("mid_out_valid", 32'(out_valid), 32'd1);
        check("mid_out_data", out_data, 32'hE1E1E1E1);
        rvalid = 1'b0;
        areset = 1'b1;
        @(negedge aclk);
        areset = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_arvalid", 32'(arvalid), 32'd0);
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_rready", 32'(rready), 32'd0);
        run_burst('{8'h31, 8'd0, 0, 32'h5A5A5A5A, -1, 0, -1, 0, 8'h30, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_read_burst_master.md
Name: axi_read_burst_master

Overview:
- AXI4 read-channel master that sits directly upstream of the AXI slave RAM and drives its AR channel while consuming its R channel.
- Accepts a simple command (start address, beat count), issues one INCR burst, and forwards returned beats to a registered valid/ready output stream.
- Checks response codes and rlast placement, then signals completion.

Parameters:
- DATA_WIDTH, 32, width of rdata and out_data.
- ADDRESS_WIDTH, 8, byte-address width.
- STROBE_WIDTH, DATA_WIDTH/8, bytes per beat.
- SIZE_LOG2, log2(STROBE_WIDTH) (2 for the default), value driven on arsize.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- areset  in  1  synchronous, active-high reset.
- cmd_addr  in  ADDRESS_WIDTH  burst start byte address.
- cmd_len  in  8  beats minus 1 (AXI encoding).
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- araddr  out  ADDRESS_WIDTH  read address.
- arlen  out  8  burst length.
- arsize  out  3  beat size.
- arburst  out  2  burst type.
- arvalid  out  1  AR valid.
- arready  in  1  AR ready.
- rdata  in  DATA_WIDTH  read data.
- rresp  in  2  read response.
- rlast  in  1  last beat.
- rvalid  in  1  R valid.
- rready  out  1  R ready.
- out_data  out  DATA_WIDTH  forwarded beat.
- out_last  out  1  set on the final counted beat.
- out_valid  out  1  output valid.
- out_ready  in  1  output ready.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky error for the current or last burst.

Behaviour:
- **States:** IDLE, ADDR, DATA, DRAIN.
  - cmd_ready = (state==IDLE).
  - arvalid = (state==ADDR).
  - rready = (state==DATA) && (!out_valid || out_ready).
- **Reset (areset=1 at an edge):**
  - State goes to IDLE.
  - arvalid, out_valid, out_last, done and err all go to 0.
  - araddr, arlen, out_data go to 0.
  - Reset mid-burst abandons the burst immediately. No drain of outstanding R beats.
- **IDLE -> ADDR** on the cmd handshake.
  - Latch araddr = cmd_addr with the low SIZE_LOG2 bits forced to 0 (aligned).
  - Latch arlen = cmd_len.
  - Load the 9-bit beat counter with cmd_len+1.
  - Clear err.
  - arvalid rises the cycle after the command handshake.
- **ADDR:**
  - arsize = SIZE_LOG2 and arburst = 2'b01 (INCR), held constant at all times.
  - araddr, arlen and arvalid stay stable until arready.
  - On arvalid && arready, go to DATA next cycle. AR is never dropped once asserted.
- **DATA:** on each rvalid && rready:
  - out_data <= rdata; out_valid <= 1; counter decrements.
  - out_last <= (counter==1).
  - err <= 1 if rresp != 2'b00.
  - err <= 1 if rlast differs from (counter==1), i.e. early rlast or missing rlast on the final beat.
  - Beat count alone terminates the burst; rlast never shortens or extends it.
  - When the accepted beat has counter==1, go to DRAIN.
- **Output register:**
  - If out_valid && out_ready and no new beat is loaded that cycle, out_valid <= 0.
  - A beat may be accepted in the same cycle the previous one leaves (full throughput: 1 beat/cycle when out_ready is held high).
  - out_data and out_last are stable while out_valid && !out_ready.
- **DRAIN:** rready = 0.
  - When out_valid==0 (final beat consumed), done = 1 for exactly one cycle and state goes to IDLE.
  - cmd_ready rises the cycle after done.
- **Error flag:** err remains held until the next command is accepted.
- **Boundary cases:**
  - cmd_len=0: single beat, out_last=1 on it.
  - cmd_len=255: counter holds 256 (9 bits).
  - Address overflow past 2**ADDRESS_WIDTH is not checked; it is the slave's concern.
  - rvalid in IDLE, ADDR or DRAIN is ignored (rready=0).
  - cmd_valid outside IDLE is ignored.

Test Plan:
- Single beat: cmd_addr=0x10, cmd_len=0; slave answers AR after 2 cycles and R data 0xA5A5A5A5, rlast=1 -> araddr=0x10, arlen=0, arsize=2, arburst=1; one out beat 0xA5A5A5A5 with out_last=1; done pulses once; err=0.
- Four-beat burst, out_ready=1: cmd_addr=0x23 (unaligned), cmd_len=3 -> araddr=0x20; beats D0..D3 on consecutive cycles appear on out_data one cycle later; only D3 has out_last; done pulses 1 cycle after D3 is consumed.
- Backpressure: same burst with out_ready low for 3 cycles at beat 1 -> rready drops; out_data holds D1 stable; no beat lost or duplicated; order D0..D3 preserved.
- Protocol errors: rresp=2'b10 on beat 2, then a second burst with rlast on beat 1 of 4 -> err=1 in both cases; burst still completes 4 beats; err clears when the next command is accepted.
- AR stall: arready held low for 5 cycles -> araddr, arlen and arvalid stable throughout; rready=0 until the AR handshake.
- Reset mid-burst: areset=1 after beat 1 of 4 -> next cycle state is IDLE, out_valid=0, arvalid=0, cmd_ready=1; a new cmd_len=0 burst then completes normally.
